// File: rtl/ov7670_capture_scaled.sv
// OV7670 byte-stream capture: assembles two-byte pixels, converts them to RGB444,
// decimates by 1/2/4 on both axes and writes them into a frame buffer of DEPTH words.
module ov7670_capture_scaled #(
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480,
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 76800
) (
  input  logic              pclk,
  input  logic              resetn,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  input  logic [1:0]        fmt,
  input  logic [1:0]        dec,
  output logic [ADDR_W-1:0] addr,
  output logic [11:0]       dout,
  output logic              we,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic [2:0]        err
);

  localparam logic [1:0] S_SYNC   = 2'd0;
  localparam logic [1:0] S_BLANK  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  localparam int COL_W = $clog2(H_ACT + 1) + 1;
  localparam int ROW_W = $clog2(V_ACT + 1) + 1;

  function automatic logic [11:0] map_pix(input logic [1:0] f, input logic [7:0] b1,
                                          input logic [7:0] b2);
    case (f)
      2'd1:    map_pix = {b1[3:0], b2};
      2'd2:    map_pix = {b1[7:4], b1[7:4], b1[7:4]};
      default: map_pix = {b1[7:4], b1[2:0], b2[7], b2[4:1]};
    endcase
  endfunction

  function automatic logic [1:0] dec_mask(input logic [1:0] dc);
    case (dc)
      2'd0:    dec_mask = 2'd0;
      2'd1:    dec_mask = 2'd1;
      default: dec_mask = 2'd3;
    endcase
  endfunction

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [11:0]       dout_q, dout_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        err_q, err_d;
  logic              phase_q, phase_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [1:0]        fmt_l_q, fmt_l_d;
  logic [1:0]        dec_l_q, dec_l_d;
  logic              href_q;
  logic [7:0]        b1_q, b1_d;
  logic              keep;

  // A pixel is kept only on columns and rows that are multiples of the decimation factor.
  assign keep = ((col_q & COL_W'(dec_mask(dec_l_q))) == '0) &&
                ((row_q & ROW_W'(dec_mask(dec_l_q))) == '0);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    dout_d  = dout_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    phase_d = phase_q;
    col_d   = col_q;
    row_d   = row_q;
    fmt_l_d = fmt_l_q;
    dec_l_d = dec_l_q;
    b1_d    = b1_q;
    case (state_q)
      S_SYNC: begin
        if (vsync) state_d = S_BLANK;
      end
      S_BLANK: begin
        if (!vsync) begin
          state_d = S_ACTIVE;
          fmt_l_d = fmt;
          dec_l_d = dec;
          addr_d  = '0;
          ptr_d   = '0;
          col_d   = '0;
          row_d   = '0;
          phase_d = 1'b0;
          err_d   = '0;
        end
      end
      S_ACTIVE: begin
        if (vsync) begin
          state_d = S_BLANK;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          phase_d = 1'b0;
          col_d   = '0;
        end else if (href) begin
          if (!phase_q) begin
            b1_d    = d;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (col_q != '1) col_d = col_q + 1'b1;
            if (keep) begin
              if (ptr_q < (ADDR_W+1)'(DEPTH)) begin
                we_d   = 1'b1;
                addr_d = ptr_q[ADDR_W-1:0];
                ptr_d  = ptr_q + 1'b1;
                dout_d = map_pix(fmt_l_q, b1_q, d);
              end else begin
                err_d[2] = 1'b1;
              end
            end
          end
        end else if (href_q) begin
          if (phase_q) err_d[0] = 1'b1;
          if (col_q != COL_W'(H_ACT)) err_d[1] = 1'b1;
          phase_d = 1'b0;
          col_d   = '0;
          row_d   = row_q + 1'b1;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_SYNC;
      addr_q  <= '0;
      ptr_q   <= '0;
      dout_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
      phase_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      fmt_l_q <= '0;
      dec_l_q <= '0;
      href_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      we_q    <= we_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      phase_q <= phase_d;
      col_q   <= col_d;
      row_q   <= row_d;
      fmt_l_q <= fmt_l_d;
      dec_l_q <= dec_l_d;
      href_q  <= href;
    end
  end

  // First byte of a pixel is pure data and needs no reset.
  always_ff @(posedge pclk) begin
    b1_q <= b1_d;
  end

  assign addr       = addr_q;
  assign dout       = dout_q;
  assign we         = we_q;
  assign frame_done = done_q;
  assign frame_cnt  = cnt_q;
  assign err        = err_q;

endmodule
